// File: rtl/fft_result_reader.sv
// Captures one cf_fft_256_8 output frame into a byte buffer, then drains it
// bin by bin over a valid/ready stream. Flags overruns and restarted captures.
module fft_result_reader #(
  parameter int FRAME_PAIRS = 128,
  parameter int DATA_W      = 16,
  parameter int OUT_W       = 8,
  parameter int OUT_MODE    = 0
) (
  input  logic              clock_c,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              sync_i,
  input  logic [DATA_W-1:0] data_0_i,
  input  logic [DATA_W-1:0] data_1_i,
  output logic [OUT_W-1:0]  out_data,
  output logic [7:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam int AW    = $clog2(FRAME_PAIRS);
  localparam int NBINS = 2 * FRAME_PAIRS;
  localparam int IW    = $clog2(NBINS) + 1;

  localparam logic [AW-1:0] LAST_PAIR = AW'(FRAME_PAIRS - 1);
  localparam logic [IW-1:0] LAST_BIN  = IW'(NBINS - 1);
  localparam logic [IW-1:0] END_BIN   = IW'(NBINS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  // Stream handshake: a bin moves on any rising edge where out_valid && out_ready.
  // While out_valid is high and out_ready low, out_data/out_index/out_last hold.
  // Every output comes straight from a flop; out_ready only feeds next-state.

  state_t            state_q, state_d;
  logic [AW-1:0]     pair_cnt_q, pair_cnt_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [7:0]        out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  // Even bins and odd bins live in separate banks so a pair lands in one cycle.
  logic [OUT_W-1:0]  even_mem_q [FRAME_PAIRS];
  logic [OUT_W-1:0]  odd_mem_q  [FRAME_PAIRS];

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [OUT_W-1:0]  wr_even;
  logic [OUT_W-1:0]  wr_odd;
  logic [AW-1:0]     rd_addr;
  logic [OUT_W-1:0]  rd_byte;
  logic              cap_evt;
  logic              accept;
  logic              lane_unused;

  function automatic logic [OUT_W-1:0] fmt_byte(input logic [OUT_W-1:0] top);
    logic [OUT_W-1:0] r;
    r = top;
    if (OUT_MODE == 1 && top[OUT_W-1]) begin
      // The most negative byte has no positive twin, so it clips to max.
      if (top == {1'b1, {(OUT_W-1){1'b0}}}) r = {1'b0, {(OUT_W-1){1'b1}}};
      else                                  r = ~top + {{(OUT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  assign cap_evt     = sync_i && enable_i;
  assign accept      = out_valid_q && out_ready;
  assign wr_even     = fmt_byte(data_0_i[DATA_W-1 -: OUT_W]);
  assign wr_odd      = fmt_byte(data_1_i[DATA_W-1 -: OUT_W]);
  assign lane_unused = ^{data_0_i[DATA_W-OUT_W-1:0], data_1_i[DATA_W-OUT_W-1:0]};
  assign rd_addr     = rd_idx_q[AW:1];
  assign rd_byte     = rd_idx_q[0] ? odd_mem_q[rd_addr] : even_mem_q[rd_addr];

  always_comb begin
    state_d      = state_q;
    pair_cnt_d   = pair_cnt_q;
    rd_idx_d     = rd_idx_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    frame_err_d  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = pair_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cap_evt) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          pair_cnt_d = AW'(1);
          state_d    = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (enable_i) begin
          wr_en = 1'b1;
          if (sync_i) begin
            // Sync mid-frame: the partial frame is abandoned and this pair is pair 0.
            frame_err_d = 1'b1;
            wr_addr     = '0;
            pair_cnt_d  = AW'(1);
          end else if (pair_cnt_q == LAST_PAIR) begin
            pair_cnt_d = '0;
            rd_idx_d   = '0;
            state_d    = S_DRAIN;
          end else begin
            pair_cnt_d = pair_cnt_q + AW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (cap_evt) overrun_d = 1'b1;
        if (accept && out_last_q) begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if ((!out_valid_q || accept) && rd_idx_q != END_BIN) begin
          // Reload the output register on the accepting edge to keep one bin per cycle.
          out_data_d  = rd_byte;
          out_index_d = 8'(rd_idx_q);
          out_last_d  = (rd_idx_q == LAST_BIN);
          out_valid_d = 1'b1;
          rd_idx_d    = rd_idx_q + IW'(1);
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_c) begin
    if (wr_en) begin
      even_mem_q[wr_addr] <= wr_even;
      odd_mem_q[wr_addr]  <= wr_odd;
    end
  end

  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pair_cnt_q   <= '0;
      rd_idx_q     <= '0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_cnt_q   <= pair_cnt_d;
      rd_idx_q     <= rd_idx_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Output-side companion to the FFT input controller. It sits on the cf_fft_256_8 result interface (sync_o, data_0_o, data_1_o) and captures one full transform frame into an internal buffer.
- It then drains the frame as a byte stream through a valid/ready handshake to a downstream consumer (UART/SPI/display logic).
- It detects overruns, where a new frame arrives before the drain finishes, and malformed frames, where sync arrives mid-capture.

Parameters:
- FRAME_PAIRS, 128, number of output pairs per frame (256-point FFT, two lanes per clock).
- DATA_W, 16, width of each core output lane.
- OUT_W, 8, width of the drained sample. It is the top OUT_W bits of a lane.
- OUT_MODE, 0, output format: 0 = signed truncation; 1 = absolute value of the truncated sample, saturated.

Ports:
- clock_c, in, 1, FFT clock (divided clock). All logic is on its rising edge.
- reset_i, in, 1, synchronous active-high reset.
- enable_i, in, 1, core enable. Capture advances only while high.
- sync_i, in, 1, connected to core sync_o. High in the same cycle as the first valid pair of a frame.
- data_0_i, in, DATA_W, core data_0_o (even bins).
- data_1_i, in, DATA_W, core data_1_o (odd bins).
- out_data, out, OUT_W, drained sample.
- out_index, out, 8, bin index of out_data (0..2*FRAME_PAIRS-1).
- out_valid, out, 1, out_data/out_index valid.
- out_ready, in, 1, consumer accepts when out_valid && out_ready.
- out_last, out, 1, high with the final bin of a frame.
- busy, out, 1, high in CAPTURE or DRAIN.
- frame_done, out, 1, one-cycle pulse after the last bin is accepted.
- overrun, out, 1, one-cycle pulse when a frame is dropped.
- frame_err, out, 1, one-cycle pulse when a capture is restarted.

Behaviour:
- Reset: reset_i sampled high at a rising edge puts the block in IDLE. Reset values:
  - out_valid, out_last, busy, frame_done, overrun, frame_err all 0.
  - out_data 0, out_index 0.
  - Capture and drain counters cleared.
- Reset has priority over every other event and aborts CAPTURE/DRAIN mid-operation. Buffer contents are don't-care after reset.
- IDLE:
  - A cycle with sync_i && enable_i writes the current pair to buffer slots 0 and 1, sets pair count to 1 and goes to CAPTURE.
  - sync_i with enable_i low is ignored.
- CAPTURE:
  - Each cycle with enable_i high stores data_0_i at index 2k and data_1_i at index 2k+1, where k is the pair count, then increments k.
  - Cycles with enable_i low hold state.
  - When pair FRAME_PAIRS-1 is stored, the next state is DRAIN.
  - sync_i && enable_i during CAPTURE with k≠0:
    - frame_err pulses for one cycle.
    - The current pair is stored as pair 0 and k is set to 1 (restart).
- Storage format:
  - Only the top OUT_W bits are stored: lane[DATA_W-1:DATA_W-OUT_W].
  - OUT_MODE=1 stores the absolute value of that signed byte. -128 saturates to 127.
- DRAIN:
  - out_valid is asserted no later than 2 cycles after entering DRAIN. This covers the registered buffer read.
  - Index order is 0,1,2,…,2*FRAME_PAIRS-1.
  - While out_valid && !out_ready, out_data, out_index and out_last hold stable.
  - After a transfer, the next bin appears within 2 cycles. Back-to-back transfers, one per cycle, are required when out_ready is held high.
  - out_last is high only with index 2*FRAME_PAIRS-1.
  - On acceptance of the last bin: out_valid drops in the next cycle, frame_done pulses in the next cycle, and the state returns to IDLE.
  - A sync_i && enable_i event in that same acceptance cycle is treated as an overrun, not a new capture.
- Overrun: sync_i && enable_i in DRAIN:
  - overrun pulses for one cycle.
  - The incoming frame is ignored entirely; its remaining pairs are not stored.
  - The drain continues unaffected.
- busy is high in CAPTURE and DRAIN and low in IDLE.
- No output is combinationally dependent on out_ready.

Test Plan:
- Reset, then sync_i with data_0=16'h1200+2k and data_1=16'h1201+2k for k=0..127, with out_ready=1 -> 256 bytes. Byte n equals (0x12+((n>>8)... truncation of 16'h1200+n)[15:8]. out_index runs 0..255, out_last occurs only at index 255, and frame_done pulses once.
- OUT_MODE=1, lanes 16'h8000 and 16'hF300 -> drained bytes 0x7F and 0x0D.
- Toggle enable_i 1/0 during capture -> stored frame is identical to the ungated case, and the capture takes 256 cycles.
- out_ready held low for 10 cycles at index 37 -> out_data and out_index are stable at 37 throughout, and no byte is lost or duplicated.
- Second sync_i at drain index 50 -> overrun pulses for 1 cycle, drain indices 51..255 are unchanged from frame 1, and the block returns to IDLE.
- sync_i at pair 60 of capture -> frame_err pulses, and the drained frame starts with the pair presented at the second sync. Separately, assert reset_i at drain index 100 -> the next cycle has out_valid=0 and busy=0, and a fresh frame captures normally.
